// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch, load and store requests
// onto a byte-wide RAM with I/O write throttling and misbranch flush.
module mem_ctrl #(
    parameter logic [31:0] IO_BASE = 32'h30000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        in_rob_misbranch,
    input  logic        in_fetcher_ce,
    input  logic [31:0] in_fetcher_addr,
    output logic        out_fetcher_ce,
    output logic [31:0] out_fetcher_data,
    input  logic        in_lsb_ce,
    input  logic [5:0]  in_lsb_size,
    input  logic        in_lsb_signed,
    input  logic [31:0] in_lsb_addr,
    output logic        out_lsb_ce,
    output logic [31:0] out_lsb_data,
    input  logic        in_rob_ce,
    input  logic [5:0]  in_rob_size,
    input  logic [31:0] in_rob_addr,
    input  logic [31:0] in_rob_data,
    output logic        out_rob_ce,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t      state;
    logic        f_pend, l_pend, r_pend, l_sgn;
    logic [31:0] f_addr, l_addr, r_addr, r_data;
    logic [5:0]  l_size, r_size;
    logic [31:0] addr, wdata, rbuf;
    logic [1:0]  cnt, last;
    logic        sgn, is_fetch;

    function automatic logic [1:0] last_idx(input logic [5:0] s);
        case (s)
            6'd1:    return 2'd0;
            6'd2:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    logic        f_req, l_req, r_req, l_g;
    logic [31:0] f_a, l_a, r_a, r_d;
    logic [5:0]  l_s, r_s;

    assign r_req = r_pend | in_rob_ce;
    assign l_req = !in_rob_misbranch && (l_pend || in_lsb_ce);
    assign f_req = !in_rob_misbranch && (f_pend || in_fetcher_ce);
    assign r_a   = r_pend ? r_addr : in_rob_addr;
    assign r_d   = r_pend ? r_data : in_rob_data;
    assign r_s   = r_pend ? r_size : in_rob_size;
    assign l_a   = l_pend ? l_addr : in_lsb_addr;
    assign l_s   = l_pend ? l_size : in_lsb_size;
    assign l_g   = l_pend ? l_sgn : in_lsb_signed;
    assign f_a   = f_pend ? f_addr : in_fetcher_addr;

    // A write byte counts as done only once it was on the bus at an active edge
    logic [1:0]  k_iss;
    logic [31:0] ia;
    logic        blk, r_blk;
    logic [7:0]  ibyte;

    assign k_iss = mem_wr ? cnt + 2'd1 : cnt;
    assign ia    = addr + {30'b0, k_iss};
    assign blk   = io_buffer_full && (ia >= IO_BASE);
    assign r_blk = io_buffer_full && (r_a >= IO_BASE);
    assign ibyte = wdata[{k_iss, 3'b000} +: 8];

    logic [31:0] rword, ldata;

    always_comb begin
        rword = rbuf;
        rword[{cnt, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        case (last)
            2'd0:    ldata = sgn ? {{24{rword[7]}}, rword[7:0]}
                                 : {24'b0, rword[7:0]};
            2'd1:    ldata = sgn ? {{16{rword[15]}}, rword[15:0]}
                                 : {16'b0, rword[15:0]};
            default: ldata = rword;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            f_pend <= 1'b0; l_pend <= 1'b0; r_pend <= 1'b0;
            f_addr <= '0; l_addr <= '0; r_addr <= '0; r_data <= '0;
            l_size <= '0; r_size <= '0; l_sgn <= 1'b0;
            addr <= '0; wdata <= '0; rbuf <= '0;
            cnt <= '0; last <= '0; sgn <= 1'b0; is_fetch <= 1'b0;
            mem_a <= '0; mem_dout <= '0; mem_wr <= 1'b0;
            out_fetcher_ce <= 1'b0; out_lsb_ce <= 1'b0; out_rob_ce <= 1'b0;
            out_fetcher_data <= '0; out_lsb_data <= '0;
        end else if (!rdy) begin
            mem_wr <= 1'b0;
            out_fetcher_ce <= 1'b0;
            out_lsb_ce <= 1'b0;
            out_rob_ce <= 1'b0;
        end else begin
            out_fetcher_ce <= 1'b0;
            out_lsb_ce <= 1'b0;
            out_rob_ce <= 1'b0;
            if (in_rob_misbranch) begin
                f_pend <= 1'b0;
                l_pend <= 1'b0;
            end else begin
                if (in_fetcher_ce) begin
                    f_pend <= 1'b1;
                    f_addr <= in_fetcher_addr;
                end
                if (in_lsb_ce) begin
                    l_pend <= 1'b1;
                    l_addr <= in_lsb_addr;
                    l_size <= in_lsb_size;
                    l_sgn  <= in_lsb_signed;
                end
            end
            if (in_rob_ce) begin
                r_pend <= 1'b1;
                r_addr <= in_rob_addr;
                r_size <= in_rob_size;
                r_data <= in_rob_data;
            end
            case (state)
                IDLE: begin
                    cnt  <= '0;
                    rbuf <= '0;
                    if (r_req) begin
                        r_pend <= 1'b0;
                        addr   <= r_a;
                        wdata  <= r_d;
                        last   <= last_idx(r_s);
                        state  <= WRITE;
                        mem_wr <= !r_blk;
                        mem_a  <= r_blk ? 32'b0 : r_a;
                        mem_dout <= r_d[7:0];
                    end else if (l_req) begin
                        l_pend   <= 1'b0;
                        addr     <= l_a;
                        last     <= last_idx(l_s);
                        sgn      <= l_g;
                        is_fetch <= 1'b0;
                        state    <= READ;
                        mem_a    <= l_a;
                    end else if (f_req) begin
                        f_pend   <= 1'b0;
                        addr     <= f_a;
                        last     <= 2'd3;
                        sgn      <= 1'b0;
                        is_fetch <= 1'b1;
                        state    <= READ;
                        mem_a    <= f_a;
                    end
                end
                READ: begin
                    if (in_rob_misbranch) begin
                        state <= IDLE;
                        mem_a <= '0;
                    end else begin
                        rbuf <= rword;
                        if (cnt == last) begin
                            state <= IDLE;
                            mem_a <= '0;
                            if (is_fetch) begin
                                out_fetcher_ce   <= 1'b1;
                                out_fetcher_data <= rword;
                            end else begin
                                out_lsb_ce   <= 1'b1;
                                out_lsb_data <= ldata;
                            end
                        end else begin
                            cnt   <= cnt + 2'd1;
                            mem_a <= addr + {30'b0, cnt + 2'd1};
                        end
                    end
                end
                WRITE: begin
                    if (mem_wr && cnt == last) begin
                        out_rob_ce <= 1'b1;
                        state  <= IDLE;
                        mem_wr <= 1'b0;
                        mem_a  <= '0;
                    end else begin
                        cnt    <= k_iss;
                        mem_wr <= !blk;
                        mem_a  <= blk ? 32'b0 : ia;
                        mem_dout <= ibyte;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: combinational byte RAM model, timing and
// ordering checks against hand-computed values.
module tb_mem_ctrl;
    logic        clk, rst, rdy, in_rob_misbranch;
    logic        in_fetcher_ce, out_fetcher_ce;
    logic [31:0] in_fetcher_addr, out_fetcher_data;
    logic        in_lsb_ce, in_lsb_signed, out_lsb_ce;
    logic [5:0]  in_lsb_size, in_rob_size;
    logic [31:0] in_lsb_addr, out_lsb_data;
    logic        in_rob_ce, out_rob_ce;
    logic [31:0] in_rob_addr, in_rob_data;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;

    logic [7:0] ram [0:1023];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_f, n_l, n_r, c_f, c_l, c_r;
    logic [31:0] d_f, d_l;
    logic [39:0] wlog [$];

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_rob_misbranch(in_rob_misbranch),
        .in_fetcher_ce(in_fetcher_ce), .in_fetcher_addr(in_fetcher_addr),
        .out_fetcher_ce(out_fetcher_ce), .out_fetcher_data(out_fetcher_data),
        .in_lsb_ce(in_lsb_ce), .in_lsb_size(in_lsb_size),
        .in_lsb_signed(in_lsb_signed), .in_lsb_addr(in_lsb_addr),
        .out_lsb_ce(out_lsb_ce), .out_lsb_data(out_lsb_data),
        .in_rob_ce(in_rob_ce), .in_rob_size(in_rob_size),
        .in_rob_addr(in_rob_addr), .in_rob_data(in_rob_data),
        .out_rob_ce(out_rob_ce),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
        .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_din = ram[mem_a[9:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wr && rdy && mem_a < 32'd1024) ram[mem_a[9:0]] = mem_dout;
    end

    always @(negedge clk) begin
        if (out_fetcher_ce) begin n_f++; c_f = cyc; d_f = out_fetcher_data; end
        if (out_lsb_ce) begin n_l++; c_l = cyc; d_l = out_lsb_data; end
        if (out_rob_ce) begin n_r++; c_r = cyc; end
        if (mem_wr) wlog.push_back({mem_a, mem_dout});
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        n_f = 0; n_l = 0; n_r = 0;
        c_f = -1; c_l = -1; c_r = -1;
        wlog.delete();
    endtask

    task automatic run_read(input string tag, input logic fetch,
                            input logic [31:0] a, input logic [5:0] sz,
                            input logic sg, input logic [31:0] exp,
                            input int lat);
        int gl;
        logic [31:0] gd;
        @(negedge clk);
        if (fetch) begin
            in_fetcher_ce = 1'b1; in_fetcher_addr = a;
        end else begin
            in_lsb_ce = 1'b1; in_lsb_addr = a;
            in_lsb_size = sz; in_lsb_signed = sg;
        end
        gl = -1;
        gd = 32'hxxxxxxxx;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            in_fetcher_ce = 1'b0;
            in_lsb_ce = 1'b0;
            if (i == 1) check({tag, " first addr"}, mem_a, a);
            if (fetch ? out_fetcher_ce : out_lsb_ce) begin
                gl = i;
                gd = fetch ? out_fetcher_data : out_lsb_data;
                break;
            end
        end
        check({tag, " latency"}, 32'(gl), 32'(lat));
        check({tag, " data"}, gd, exp);
    endtask

    int base;
    logic [7:0] eb [4];

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'h00; ram[3] = 8'h00;
        ram[4] = 8'h93; ram[5] = 8'h00; ram[6] = 8'h10; ram[7] = 8'h00;
        ram[8] = 8'hAA; ram[9] = 8'hBB; ram[10] = 8'hCC; ram[11] = 8'hDD;
        ram[32'h100] = 8'h80;
        ram[32'h110] = 8'hFF; ram[32'h111] = 8'h80;
        ram[32'h120] = 8'h78; ram[32'h121] = 8'h56;
        ram[32'h122] = 8'h34; ram[32'h123] = 8'hF2;
        ram[32'h130] = 8'h34; ram[32'h131] = 8'h12;
        ram[32'h300] = 8'h11; ram[32'h301] = 8'h22;
        ram[32'h302] = 8'h33; ram[32'h303] = 8'h44;
        eb[0] = 8'hEF; eb[1] = 8'hBE; eb[2] = 8'hAD; eb[3] = 8'hDE;

        rst = 1'b1; rdy = 1'b1; in_rob_misbranch = 1'b0;
        in_fetcher_ce = 1'b0; in_fetcher_addr = '0;
        in_lsb_ce = 1'b0; in_lsb_size = '0; in_lsb_signed = 1'b0;
        in_lsb_addr = '0;
        in_rob_ce = 1'b0; in_rob_size = '0; in_rob_addr = '0;
        in_rob_data = '0; io_buffer_full = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);
        check("reset mem_a", mem_a, 32'h0);
        check("reset mem_wr", {31'b0, mem_wr}, 32'h0);
        check("reset mem_dout", {24'b0, mem_dout}, 32'h0);
        check("reset ce", {29'b0, out_fetcher_ce, out_lsb_ce, out_rob_ce}, 0);
        check("reset fdata", out_fetcher_data, 32'h0);
        check("reset ldata", out_lsb_data, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        run_read("lb signed", 1'b0, 32'h100, 6'd1, 1'b1, 32'hFFFFFF80, 2);
        run_read("lb unsigned", 1'b0, 32'h100, 6'd1, 1'b0, 32'h00000080, 2);
        run_read("lh signed", 1'b0, 32'h110, 6'd2, 1'b1, 32'hFFFF80FF, 3);
        run_read("lh unsigned", 1'b0, 32'h110, 6'd2, 1'b0, 32'h000080FF, 3);
        run_read("lw signed", 1'b0, 32'h120, 6'd4, 1'b1, 32'hF2345678, 5);
        run_read("size3 load", 1'b0, 32'h120, 6'd3, 1'b0, 32'hF2345678, 5);
        run_read("fetch", 1'b1, 32'h0, 6'd0, 1'b0, 32'h00000513, 5);

        // simultaneous store, load and fetch
        @(negedge clk);
        clear_mon();
        base = cyc;
        in_rob_ce = 1'b1; in_rob_size = 6'd4;
        in_rob_addr = 32'h200; in_rob_data = 32'hDEADBEEF;
        in_lsb_ce = 1'b1; in_lsb_size = 6'd4; in_lsb_signed = 1'b0;
        in_lsb_addr = 32'h300;
        in_fetcher_ce = 1'b1; in_fetcher_addr = 32'h4;
        @(negedge clk);
        in_rob_ce = 1'b0; in_lsb_ce = 1'b0; in_fetcher_ce = 1'b0;
        repeat (20) @(negedge clk);
        check("sim store cycle", 32'(c_r - base), 32'd5);
        check("sim load cycle", 32'(c_l - base), 32'd10);
        check("sim fetch cycle", 32'(c_f - base), 32'd15);
        check("sim pulse counts", {8'(n_f), 8'(n_l), 8'(n_r)}, 32'h010101);
        check("sim load data", d_l, 32'h44332211);
        check("sim fetch data", d_f, 32'h00100093);
        check("sim write count", 32'(wlog.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (wlog.size() > k) begin
                check("sim write addr", wlog[k][39:8], 32'h200 + 32'(k));
                check("sim write byte", {24'b0, wlog[k][7:0]}, {24'b0, eb[k]});
            end
        end

        // misbranch on byte 2 of a fetch, store pulsed alongside
        @(negedge clk);
        clear_mon();
        base = cyc;
        in_fetcher_ce = 1'b1; in_fetcher_addr = 32'h8;
        @(negedge clk);
        in_fetcher_ce = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mis byte2 addr", mem_a, 32'hA);
        in_rob_misbranch = 1'b1;
        in_rob_ce = 1'b1; in_rob_size = 6'd1;
        in_rob_addr = 32'h220; in_rob_data = 32'h0000005A;
        @(negedge clk);
        in_rob_misbranch = 1'b0; in_rob_ce = 1'b0;
        check("mis mem_a", mem_a, 32'h0);
        check("mis mem_wr", {31'b0, mem_wr}, 32'h0);
        @(negedge clk);
        check("mis store addr", mem_a, 32'h220);
        check("mis store wr", {31'b0, mem_wr}, 32'h1);
        repeat (8) @(negedge clk);
        check("mis fetch pulses", 32'(n_f), 32'd0);
        check("mis store cycle", 32'(c_r - base), 32'd6);
        check("mis ram", {24'b0, ram[32'h220]}, 32'h5A);

        // I/O write throttled for three edges
        @(negedge clk);
        io_buffer_full = 1'b1;
        in_rob_ce = 1'b1; in_rob_size = 6'd1;
        in_rob_addr = 32'h30000; in_rob_data = 32'h00000041;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            in_rob_ce = 1'b0;
            check("io held", {31'b0, mem_wr}, 32'h0);
        end
        io_buffer_full = 1'b0;
        @(negedge clk);
        check("io wr", {31'b0, mem_wr}, 32'h1);
        check("io addr", mem_a, 32'h30000);
        check("io byte", {24'b0, mem_dout}, 32'h41);
        @(negedge clk);
        check("io done", {31'b0, out_rob_ce}, 32'h1);
        check("io wr off", {31'b0, mem_wr}, 32'h0);

        // pause for two edges during byte 1 of an LH
        @(negedge clk);
        clear_mon();
        in_lsb_ce = 1'b1; in_lsb_size = 6'd2; in_lsb_signed = 1'b0;
        in_lsb_addr = 32'h130;
        @(negedge clk);
        in_lsb_ce = 1'b0;
        check("pause a0", mem_a, 32'h130);
        @(negedge clk);
        check("pause a1", mem_a, 32'h131);
        rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rdy = 1'b1;
        check("pause no pulse", {31'b0, out_lsb_ce}, 32'h0);
        @(negedge clk);
        check("pause pulse", {31'b0, out_lsb_ce}, 32'h1);
        check("pause data", out_lsb_data, 32'h00001234);
        repeat (3) @(negedge clk);
        check("pause count", 32'(n_l), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
